// File: rtl/diff_rebuild.sv
// diff_rebuild: rebuilds the partner word B = A ^ (1 << pos) from a DIFF bit index,
// one mask shift per cycle. Define DIFF_REBUILD_FAST_EN for a single-cycle barrel decode.
module diff_rebuild #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH):0]   pos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         b,
  output logic [WIDTH-1:0]         mask,
  output logic                     clamped
);

  localparam int PW = $clog2(WIDTH) + 1;
  localparam logic [PW-1:0]    WIDTH_P = PW'(WIDTH);
  localparam logic [PW-1:0]    CNT_ONE = PW'(1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             clamped_req_q, clamped_req_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mask_out_q, mask_out_d;
  logic             clamped_out_q, clamped_out_d;
  logic [PW-1:0]    pos_sat_s;
  logic             pos_over_s;

`ifdef DIFF_REBUILD_FAST_EN
  logic [WIDTH-1:0] decode_s;

  // Out-of-range indices decode to an empty mask, matching a full shift-out.
  function automatic logic [WIDTH-1:0] onehot(input logic [PW-1:0] p);
    if (p < WIDTH_P) begin
      onehot = ONE << p;
    end else begin
      onehot = {WIDTH{1'b0}};
    end
  endfunction
`else
  logic [WIDTH-1:0] mask_q, mask_d;
`endif

  assign pos_over_s = (pos > WIDTH_P);
  assign pos_sat_s  = pos_over_s ? WIDTH_P : pos;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign b         = b_q;
  assign mask      = mask_out_q;
  assign clamped   = clamped_out_q;

`ifdef DIFF_REBUILD_FAST_EN
  assign decode_s = onehot(cnt_q);
`endif

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    cnt_d         = cnt_q;
    clamped_req_d = clamped_req_q;
    b_d           = b_q;
    mask_out_d    = mask_out_q;
    clamped_out_d = clamped_out_q;
`ifndef DIFF_REBUILD_FAST_EN
    mask_d        = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d           = a;
          cnt_d         = pos_sat_s;
          clamped_req_d = pos_over_s;
`ifndef DIFF_REBUILD_FAST_EN
          mask_d        = ONE;
`endif
          state_d       = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef DIFF_REBUILD_FAST_EN
        b_d           = a_q ^ decode_s;
        mask_out_d    = decode_s;
        clamped_out_d = clamped_req_q;
        state_d       = DONE;
`else
        if (cnt_q != {PW{1'b0}}) begin
          // WIDTH shifts push the single bit out entirely, giving b == a for pos == WIDTH.
          mask_d = mask_q << 1;
          cnt_d  = cnt_q - CNT_ONE;
        end else begin
          b_d           = a_q ^ mask_q;
          mask_out_d    = mask_q;
          clamped_out_d = clamped_req_q;
          state_d       = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= {WIDTH{1'b0}};
      cnt_q         <= {PW{1'b0}};
      clamped_req_q <= 1'b0;
      b_q           <= {WIDTH{1'b0}};
      mask_out_q    <= {WIDTH{1'b0}};
      clamped_out_q <= 1'b0;
`ifndef DIFF_REBUILD_FAST_EN
      mask_q        <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      cnt_q         <= cnt_d;
      clamped_req_q <= clamped_req_d;
      b_q           <= b_d;
      mask_out_q    <= mask_out_d;
      clamped_out_q <= clamped_out_d;
`ifndef DIFF_REBUILD_FAST_EN
      mask_q        <= mask_d;
`endif
    end
  end

endmodule
